sha2_block_padder: RTL

//  Next-generation SHA-2 message padder. Accepts a byte stream of arbitrary length on a parametrised-width AXI-Stream slave.

---
 rtl/sha2_block_padder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/sha2_block_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha2_block_padder
// Description : SHA-2 message padder. Gathers an AXI-Stream byte stream into
//               512b (SHA-256) or 1024b (SHA-384/512) blocks, appends the
//               0x80 / zero / big-endian bit-length padding and hands out one
//               block per m_axis handshake, tlast on the final block.
//               Optional protocol checking: define SHA2_PADDER_ERRCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sha2_block_padder #(
  parameter int S_DATA_WIDTH   = 64,
  parameter int LEN_CNT_WIDTH  = 64,
  parameter int SHA512_SUPPORT = 1
) (
  input  logic                      axi_aclk,
  input  logic                      reset,
  input  logic                      sha_mode,
  input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [1023:0]             m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tmode,
  output logic                      err
);

  localparam int         c_BEAT_BYTES  = S_DATA_WIDTH / 8;
  localparam logic [7:0] c_BEAT_BYTES8 = 8'(S_DATA_WIDTH / 8);

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_ACCUM     = 3'd1;
  localparam logic [2:0] c_ST_PAD       = 3'd2;
  localparam logic [2:0] c_ST_EXTRA     = 3'd3;
  localparam logic [2:0] c_ST_EMIT      = 3'd4;
  localparam logic [2:0] c_ST_EMIT_LAST = 3'd5;

  // Block buffer always kept in 1024b order: byte i lives at [1023-8i -: 8].
  // A SHA-256 block therefore occupies the upper half and is shifted down
  // onto the output bus.
  logic [2:0]               r_state;
  logic [1023:0]            r_buf;
  logic [7:0]               r_fill;
  logic [LEN_CNT_WIDTH-1:0] r_cnt;
  logic                     r_mode;
  logic                     r_extra80;
  logic                     r_go_extra;

  logic                     w_accepting;
  logic                     w_s_fire;
  logic                     w_mode_in;
  logic                     w_mode_eff;
  logic [7:0]               w_blk_bytes;
  logic [7:0]               w_pad_limit;
  logic [S_DATA_WIDTH-1:0]  w_beat_be;
  logic [7:0]               w_pop;
  logic [10:0]              w_shift;
  logic [1023:0]            w_ins;
  logic [1023:0]            w_ins_msk;
  logic [1023:0]            w_buf_beat;
  logic [1023:0]            w_buf_pad;
  logic [LEN_CNT_WIDTH-1:0] w_cnt_base;
  logic [LEN_CNT_WIDTH-1:0] w_cnt_next;
  logic [7:0]               w_fill_full;
  logic [7:0]               w_fill_last;
  logic                     w_full;
  logic [127:0]             w_len128;
  logic [1023:0]            w_len_blk;
  logic [1023:0]            w_extra_blk;

  assign w_mode_in     = (SHA512_SUPPORT != 0) ? sha_mode : 1'b0;
  assign w_accepting   = (r_state == c_ST_IDLE) || (r_state == c_ST_ACCUM);
  assign s_axis_tready = w_accepting & ~reset;
  assign w_s_fire      = s_axis_tvalid & s_axis_tready;

  // The first beat of a message is processed in IDLE, so its block size comes
  // straight from sha_mode rather than from the latched copy.
  assign w_mode_eff  = (r_state == c_ST_IDLE) ? w_mode_in : r_mode;
  assign w_blk_bytes = w_mode_eff ? 8'd128 : 8'd64;
  assign w_pad_limit = r_mode ? 8'd111 : 8'd55;

  // Re-order beat bytes so the earliest byte is most significant; bytes not
  // kept are forced to zero.
  genvar gj;
  generate
    for (gj = 0; gj < c_BEAT_BYTES; gj = gj + 1) begin : g_beat_bytes
      assign w_beat_be[S_DATA_WIDTH-1-8*gj -: 8] =
        s_axis_tdata[8*gj +: 8] & {8{s_axis_tkeep[gj]}};
    end
  endgenerate

  // Number of valid bytes in the current beat.
  always_comb begin
    w_pop = 8'd0;
    for (int j = 0; j < c_BEAT_BYTES; j++) begin
      w_pop = w_pop + {7'd0, s_axis_tkeep[j]};
    end
  end

  assign w_shift    = {r_fill, 3'b000};
  assign w_ins      = {w_beat_be, {(1024-S_DATA_WIDTH){1'b0}}} >> w_shift;
  assign w_ins_msk  = {{S_DATA_WIDTH{1'b1}}, {(1024-S_DATA_WIDTH){1'b0}}} >> w_shift;
  assign w_buf_beat = (r_buf & ~w_ins_msk) | w_ins;

  // Non-last beats always advance by a whole beat so the fill pointer stays
  // beat-aligned; the last beat advances by the bytes actually kept.
  assign w_fill_full = r_fill + c_BEAT_BYTES8;
  assign w_fill_last = r_fill + w_pop;
  assign w_full      = (w_fill_full == w_blk_bytes);

  assign w_cnt_base = (r_state == c_ST_IDLE) ? '0 : r_cnt;
  assign w_cnt_next = w_cnt_base + LEN_CNT_WIDTH'({w_pop, 3'b000});

  // Keep bytes below the fill pointer, 0x80 at the pointer, zeros after.
  assign w_buf_pad = (r_buf & ~({1024{1'b1}} >> w_shift)) |
                     ({8'h80, 1016'd0} >> w_shift);

  // Bit length placed in the final 8 (SHA-256) or 16 (SHA-512) block bytes.
  assign w_len128    = 128'(r_cnt);
  assign w_len_blk   = r_mode ? {896'd0, w_len128}
                              : {448'd0, w_len128[63:0], 512'd0};
  assign w_extra_blk = (r_extra80 ? {8'h80, 1016'd0} : 1024'd0) | w_len_blk;

  assign m_axis_tdata  = r_mode ? r_buf : {512'd0, r_buf[1023:512]};
  assign m_axis_tvalid = (r_state == c_ST_EMIT) || (r_state == c_ST_EMIT_LAST);
  assign m_axis_tlast  = (r_state == c_ST_EMIT_LAST);
  assign m_axis_tmode  = r_mode;

  // Main control: accumulate beats, pad, and hold blocks until accepted.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      r_state    <= c_ST_IDLE;
      r_buf      <= '0;
      r_fill     <= 8'd0;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_extra80  <= 1'b0;
      r_go_extra <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_ACCUM: begin
          if (w_s_fire) begin
            r_buf <= w_buf_beat;
            r_cnt <= w_cnt_next;
            if (r_state == c_ST_IDLE) begin
              r_mode <= w_mode_in;
            end
            if (s_axis_tlast) begin
              r_fill  <= w_fill_last;
              r_state <= c_ST_PAD;
            end else if (w_full) begin
              r_fill     <= 8'd0;
              r_go_extra <= 1'b0;
              r_state    <= c_ST_EMIT;
            end else begin
              r_fill  <= w_fill_full;
              r_state <= c_ST_ACCUM;
            end
          end
        end
        c_ST_PAD: begin
          if (r_fill == (r_mode ? 8'd128 : 8'd64)) begin
            // Data exactly filled the block: send it untouched, 0x80 goes
            // into the extra block.
            r_extra80  <= 1'b1;
            r_go_extra <= 1'b1;
            r_state    <= c_ST_EMIT;
          end else if (r_fill <= w_pad_limit) begin
            r_buf   <= w_buf_pad | w_len_blk;
            r_state <= c_ST_EMIT_LAST;
          end else begin
            r_buf      <= w_buf_pad;
            r_extra80  <= 1'b0;
            r_go_extra <= 1'b1;
            r_state    <= c_ST_EMIT;
          end
        end
        c_ST_EXTRA: begin
          r_buf      <= w_extra_blk;
          r_go_extra <= 1'b0;
          r_state    <= c_ST_EMIT_LAST;
        end
        c_ST_EMIT: begin
          if (m_axis_tready) begin
            r_state <= r_go_extra ? c_ST_EXTRA : c_ST_ACCUM;
          end
        end
        c_ST_EMIT_LAST: begin
          if (m_axis_tready) begin
            r_fill  <= 8'd0;
            r_cnt   <= '0;
            r_state <= c_ST_IDLE;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

`ifdef SHA2_PADDER_ERRCHK_EN
  logic w_keep_noncontig;
  logic w_keep_partial;
  logic w_mode_chg;

  // A contiguous-from-bit0 mask plus one has no bits in common with itself.
  assign w_keep_noncontig = |(s_axis_tkeep & (s_axis_tkeep + c_BEAT_BYTES'(1)));
  assign w_keep_partial   = ~s_axis_tlast & ~(&s_axis_tkeep);
  assign w_mode_chg       = (r_state == c_ST_ACCUM) && (w_mode_in != r_mode);

  logic r_err;

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_s_fire && (w_keep_noncontig || w_keep_partial || w_mode_chg)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
